uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the UART. It synchronizes the raw serial line, detects the start-bit falling edge and sequences the oversampled sampling of start, data, optional parity and stop bits. It sits between the pad-side `rx` input and the receive FIFO/host interface, and it is paced by the shared oversample tick from the baud generator. It emits one byte per valid frame and flags framing and parity errors.

## Interface
- `OS`, 16: oversample ticks per bit; even, ≥4.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  one-`clk` pulse at OS× baud rate.
- `rx`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `rx_data`  out  DATA_BITS  last received data, LSB = first bit on the wire.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` holds a good frame.
- `frame_err`  out  1  one-cycle pulse; the stop bit was sampled low.
- `parity_err`  out  1  one-cycle pulse; parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`s1`, `s2`) and a delay flop `s3`. A falling edge is `s2 == 0 & s3 == 1`, evaluated every `clk`. It does not depend on `baud_tick`.
- Tick counter `tcnt`: width $clog2(OS). It advances only on `baud_tick`. Bit counter `bcnt`: width $clog2(DATA_BITS).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge, clear `tcnt` and go to START. A line held low (break) generates no edge and does not re-arm the receiver.
  - START: on the `baud_tick` where `tcnt == OS/2-1`, sample `s2`.
    - 0: clear `tcnt` and `bcnt`, go to DATA.
    - 1: treat as a glitch and return to IDLE with no output pulse.
  - DATA: on the `baud_tick` where `tcnt == OS-1`, shift `s2` into the shift register MSB-first (so the first bit ends in bit 0) and clear `tcnt`.
    - After `bcnt == DATA_BITS-1`, go to PARITY if `UART_RX_PARITY_EN` is defined, else to STOP.
  - PARITY: on `tcnt == OS-1`, capture the bit and go to STOP.
  - STOP: on `tcnt == OS-1`, sample `s2`.
    - Load `rx_data` from the shift register in both cases.
    - Pulse `rx_valid` if the stop bit is 1 and parity is OK. Pulse `frame_err` if it is 0.
    - Return to IDLE.
- All sampling points fall mid-bit, at OS/2 ticks after the detected edge plus integer multiples of OS.
- A falling edge seen while not in IDLE is ignored.
- `rst` asserted mid-frame aborts the frame: no pulse is issued and the FSM returns to IDLE.

## Timing
- Reset values: `rx_data = 0`, `rx_valid = 0`, `frame_err = 0`, `parity_err = 0`, `busy = 0`, state IDLE, `s1`/`s2`/`s3` = 1.
- Edge-detect latency: 2–3 `clk` from the `rx` transition. START is entered on the edge after `s2` falls.
- All outputs are registered.
  - `rx_valid`, `frame_err` and `parity_err` are high for exactly one `clk`, in the cycle after the clock edge that registers the stop-bit sampling tick.
  - `rx_data` changes on that same edge and holds until the next frame completes.
- `busy` rises the cycle after the falling edge is registered and falls together with the completion pulse, or on START rejection.
- Back-to-back frames: a start edge arriving half a bit after the stop-sample point must be accepted, since the FSM is back in IDLE by then.
- `baud_tick` asserted for more than 1 `clk` is illegal; behaviour is undefined.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state and even-parity checking, with one extra bit time per frame.
  - `parity_err` pulses in the same cycle `rx_valid` would have; `rx_valid` is suppressed on a mismatch.
  - If both stop and parity are bad, both `frame_err` and `parity_err` pulse.
- Undefined: PARITY is unreachable, `parity_err` is constant 0, and the frame is start + DATA_BITS + stop.

## Test plan
- Good frame (`OS=16`, `DATA_BITS=8`): send 0xA5 (wire order 1,0,1,0,0,1,0,1) with stop 1. Expect `rx_data = 0xA5`, one `rx_valid` pulse, no errors, and `busy` high for ~9.5 bit times.
- Start glitch: drive `rx` low for 4 ticks, then high. Expect return to IDLE by tick 8, no pulses, `rx_data` unchanged.
- Framing error: send 0x3C with stop bit 0, then hold the line low for 3 bit times. Expect `frame_err` for one cycle, `rx_data = 0x3C`, `rx_valid` 0, and no re-arm until `rx` goes high and falls again.
- Back-to-back: send 0x00 then 0xFF with no idle gap. Expect two `rx_valid` pulses 10 bit times apart, with data 0x00 then 0xFF.
- Reset mid-frame: assert `rst` during data bit 3 of 0x55. Expect all outputs zero immediately and `busy` 0. A following 0x81 frame is received correctly.
- `UART_RX_PARITY_EN`:
  - Send 0x07 with parity bit 1 (even parity OK). Expect `rx_valid` with 0x07.
  - Resend 0x07 with parity bit 0. Expect `parity_err` with no `rx_valid`.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-byte and status bundle between the UART receive
// controller (master) and the receive FIFO / host side (slave).
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input parity_err,
        input busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Synchronizes rx, detects the start
// edge and samples start, data, optional parity and stop bits mid-bit using
// the oversample tick. Emits one byte per frame plus framing/parity flags.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data).
module uart_rx_ctrl #(
    parameter int OS        = 16,
    parameter int DATA_BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            baud_tick,
    input  logic            rx,
    uart_rx_ctrl_if.master  rx_if
);

    localparam int TW = $clog2(OS);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_HALF = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_nx;
    logic                  s1, s2, s3;
    logic                  fall;
    logic [TW-1:0]         tcnt, tcnt_nx;
    logic [BW-1:0]         bcnt, bcnt_nx;
    logic [DATA_BITS-1:0]  shreg, shreg_nx;
    logic [DATA_BITS-1:0]  data_q, data_nx;
    logic                  valid_q, valid_nx;
    logic                  ferr_q, ferr_nx;
    logic                  busy_q, busy_nx;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit, par_bit_nx;
    logic                  par_ok;
    logic                  perr_q, perr_nx;
`endif

    // Two-flop synchronizer plus a delay flop for start-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = ~s2 & s3;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, counter, shift register and output-pulse logic
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bcnt_nx  = bcnt;
        shreg_nx = shreg;
        data_nx  = data_q;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nx = par_bit;
        perr_nx    = 1'b0;
        par_ok     = ~(^{shreg, par_bit});
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    tcnt_nx  = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tcnt == T_HALF) begin
                        if (!s2) begin
                            tcnt_nx  = '0;
                            bcnt_nx  = '0;
                            state_nx = DATA;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tcnt == T_FULL) begin
                        shreg_nx = {s2, shreg[DATA_BITS-1:1]};
                        tcnt_nx  = '0;
                        if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = PARITY;
`else
                            state_nx = STOP;
`endif
                        end else begin
                            bcnt_nx = bcnt + 1'b1;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (baud_tick) begin
                    if (tcnt == T_FULL) begin
                        par_bit_nx = s2;
                        tcnt_nx    = '0;
                        state_nx   = STOP;
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
`else
                state_nx = IDLE;
`endif
            end
            STOP: begin
                if (baud_tick) begin
                    if (tcnt == T_FULL) begin
                        data_nx  = shreg;
                        ferr_nx  = ~s2;
`ifdef UART_RX_PARITY_EN
                        valid_nx = s2 & par_ok;
                        perr_nx  = ~par_ok;
`else
                        valid_nx = s2;
`endif
                        state_nx = IDLE;
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            tcnt    <= tcnt_nx;
            bcnt    <= bcnt_nx;
            shreg   <= shreg_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            ferr_q  <= ferr_nx;
            busy_q  <= busy_nx;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit and registered parity-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            par_bit <= par_bit_nx;
            perr_q  <= perr_nx;
        end
    end

    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a scoreboard of
// expected completion pulses. Honours UART_RX_PARITY_EN for the parity steps.
module tb_uart_rx_ctrl;

    localparam int OS          = 16;
    localparam int DATA_BITS   = 8;
    localparam int TICK_DIV    = 4;
    localparam int CLK_PER_BIT = OS * TICK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk;
    logic rst;
    logic baud_tick;
    logic rx;
    logic [1:0] tick_div;

    int   errors;
    int   checks;
    int   cycle;
    int   busy_cycles;
    exp_t exp_q[$];
    int   valid_times[$];

    uart_rx_ctrl_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_ctrl #(
        .OS(OS),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .baud_tick(baud_tick),
        .rx(rx),
        .rx_if(rx_if)
    );

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: one clk pulse every TICK_DIV cycles
    always @(posedge clk) begin
        tick_div  <= tick_div + 2'd1;
        baud_tick <= (tick_div == 2'd2);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on rx, LSB first, each bit CLK_PER_BIT cycles long
    task automatic applyStimulus(input logic [7:0] d, input logic stop_b,
                                 input logic par_b);
        rx = 1'b0;
        waitClk(CLK_PER_BIT);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = d[i];
            waitClk(CLK_PER_BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        waitClk(CLK_PER_BIT);
`else
        if (par_b === 1'bx) rx = 1'b1;
`endif
        rx = stop_b;
        waitClk(CLK_PER_BIT);
    endtask

    task automatic expectFrame(input logic [7:0] d, input logic v,
                               input logic fe, input logic pe);
        exp_t e;
        e.data  = d;
        e.valid = v;
        e.ferr  = fe;
        e.perr  = pe;
        exp_q.push_back(e);
    endtask

    task automatic checkIdleOutputs(input string tag, input logic [7:0] d);
        checkOutput({tag, "_data"},   32'(rx_if.rx_data), 32'(d));
        checkOutput({tag, "_valid"},  32'(rx_if.rx_valid), 32'd0);
        checkOutput({tag, "_ferr"},   32'(rx_if.frame_err), 32'd0);
        checkOutput({tag, "_perr"},   32'(rx_if.parity_err), 32'd0);
        checkOutput({tag, "_busy"},   32'(rx_if.busy), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (rx_if.busy) busy_cycles++;
        if (!rst && (rx_if.rx_valid || rx_if.frame_err || rx_if.parity_err)) begin
            if (rx_if.rx_valid) valid_times.push_back(cycle);
            checkOutput("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_data",  32'(rx_if.rx_data), 32'(e.data));
                checkOutput("sb_valid", 32'(rx_if.rx_valid), 32'(e.valid));
                checkOutput("sb_ferr",  32'(rx_if.frame_err), 32'(e.ferr));
                checkOutput("sb_perr",  32'(rx_if.parity_err), 32'(e.perr));
            end
        end
    end

    initial begin
        int b0;
        int n0;
        int gap;
        errors   = 0;
        checks   = 0;
        cycle    = 0;
        busy_cycles = 0;
        tick_div = 2'd0;
        baud_tick = 1'b0;
        rx  = 1'b1;
        rst = 1'b1;
        waitClk(5);
        checkIdleOutputs("reset", 8'h00);
        rst = 1'b0;
        waitClk(CLK_PER_BIT);

        $display("[TB] good frame 0xA5");
        expectFrame(8'hA5, 1'b1, 1'b0, 1'b0);
        b0 = busy_cycles;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitClk(CLK_PER_BIT);
        checkIdleOutputs("a5_after", 8'hA5);
        checkOutput("a5_busy_len", 32'((busy_cycles - b0) >= 600 && (busy_cycles - b0) <= 612), 32'd1);

        $display("[TB] start glitch");
        rx = 1'b0;
        waitClk(8);
        checkOutput("glitch_busy_hi", 32'(rx_if.busy), 32'd1);
        waitClk(8);
        rx = 1'b1;
        waitClk(34);
        checkIdleOutputs("glitch_after", 8'hA5);
        waitClk(CLK_PER_BIT);

        $display("[TB] framing error 0x3C");
        expectFrame(8'h3C, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitClk(3 * CLK_PER_BIT);
        checkIdleOutputs("break_no_rearm", 8'h3C);
        rx = 1'b1;
        waitClk(CLK_PER_BIT);

        $display("[TB] back-to-back 0x00, 0xFF");
        n0 = valid_times.size();
        expectFrame(8'h00, 1'b1, 1'b0, 1'b0);
        expectFrame(8'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        waitClk(CLK_PER_BIT);
        checkOutput("b2b_count", 32'(valid_times.size() - n0), 32'd2);
        gap = (valid_times.size() >= n0 + 2) ? valid_times[n0 + 1] - valid_times[n0] : 0;
`ifdef UART_RX_PARITY_EN
        checkOutput("b2b_gap", 32'(gap), 32'(11 * CLK_PER_BIT));
`else
        checkOutput("b2b_gap", 32'(gap), 32'(10 * CLK_PER_BIT));
`endif
        checkIdleOutputs("b2b_after", 8'hFF);

        $display("[TB] reset during data bit 3 of 0x55");
        rx = 1'b0;
        waitClk(CLK_PER_BIT);
        rx = 1'b1;
        waitClk(CLK_PER_BIT);
        rx = 1'b0;
        waitClk(CLK_PER_BIT);
        rx = 1'b1;
        waitClk(CLK_PER_BIT);
        rx = 1'b0;
        waitClk(20);
        checkOutput("rstmid_busy_hi", 32'(rx_if.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkIdleOutputs("rstmid", 8'h00);
        rx = 1'b1;
        waitClk(4);
        rst = 1'b0;
        waitClk(CLK_PER_BIT);
        checkIdleOutputs("rstmid_after", 8'h00);

        $display("[TB] frame 0x81 after reset");
        expectFrame(8'h81, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        waitClk(CLK_PER_BIT);
        checkIdleOutputs("x81_after", 8'h81);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity good 0x07");
        expectFrame(8'h07, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h07, 1'b1, 1'b1);
        waitClk(CLK_PER_BIT);
        checkIdleOutputs("par_ok_after", 8'h07);

        $display("[TB] parity bad 0x07");
        expectFrame(8'h07, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h07, 1'b1, 1'b0);
        waitClk(CLK_PER_BIT);

        $display("[TB] parity bad and stop bad 0x07");
        expectFrame(8'h07, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h07, 1'b0, 1'b0);
        rx = 1'b1;
        waitClk(CLK_PER_BIT);
`endif

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
